// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, synchroniser depth and width helpers
// used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  // Flops between the asynchronous line and the sampling logic.
  localparam int unsigned SYNC_STAGES = 2;

  // Width of a counter that holds 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy count that holds 0..depth.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A pop in the same cycle as a push frees
// the slot first, so a push into a full FIFO is accepted when it coincides with a pop.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = cnt_width(DEPTH),
  localparam int unsigned LW = level_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Head is masked while empty so the output reads zero out of reset.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally (power-of-two depth); occupancy tracked separately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a receive FIFO, with sticky frame/overrun error flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD   = 1'b0
`endif
  , localparam int unsigned CNT_W     = level_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx,
  input  logic              en,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [CNT_W-1:0]  level,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic              parity_err,
`endif
  input  logic              clr_err
);

  localparam int unsigned BC_W  = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IDX_W = cnt_width(DATA_W);
  localparam logic [BC_W-1:0]  CntLast  = BC_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0]  CntHalf  = BC_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] DataLast = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] StopLast = IDX_W'(STOP_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic                   w_rx_s;
  uart_rx_state_e         r_state;
  logic [BC_W-1:0]        r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_W-1:0]      r_shift;
  logic                   r_stop_ok;
  logic                   r_wait_high;
  logic                   r_push;
  logic                   r_frame_err;
  logic                   r_overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                   r_parity_err;
`endif
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_overrun;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Line synchroniser plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rx_d <= w_rx_s;
    end
  end

  // Receive FSM: mid-bit sampling, shift-in LSB first, stop check and push request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_stop_ok    <= 1'b1;
      r_wait_high  <= 1'b0;
      r_push       <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      // Clear first so an error set later in this block wins.
      if (clr_err) begin
        r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
      unique case (r_state)
        StIdle: begin
          r_cnt       <= '0;
          r_idx       <= '0;
          r_stop_ok   <= 1'b1;
          r_wait_high <= 1'b0;
          if (en && r_rx_d && !w_rx_s) r_state <= StStart;
        end
        StStart: begin
          if (r_cnt == CntHalf) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? StIdle : StData;
          end else begin
            r_cnt <= r_cnt + BC_W'(1);
          end
        end
        StData: begin
          if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
            if (r_idx == DataLast) begin
              r_idx   <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + BC_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_state <= StStop;
            if (w_rx_s != ((^r_shift) ^ PARITY_ODD)) r_parity_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + BC_W'(1);
          end
        end
`endif
        StStop: begin
          if (r_wait_high) begin
            // After a framing error, hold off until the line returns high.
            if (w_rx_s) begin
              r_wait_high <= 1'b0;
              r_state     <= StIdle;
            end
          end else if (r_cnt == CntLast) begin
            r_cnt <= '0;
            if (r_idx == StopLast) begin
              r_idx <= '0;
              if (r_stop_ok && w_rx_s) begin
                r_push  <= 1'b1;
                r_state <= StIdle;
              end else begin
                r_frame_err <= 1'b1;
                r_wait_high <= 1'b1;
              end
            end else begin
              r_idx     <= r_idx + IDX_W'(1);
              r_stop_ok <= r_stop_ok & w_rx_s;
            end
          end else begin
            r_cnt <= r_cnt + BC_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_pop     = valid_out && ready_out;
  assign w_overrun = r_push && w_full && !w_pop;

  // Overrun flag: set when a completed word finds no free slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun_err <= 1'b0;
    end else if (w_overrun) begin
      r_overrun_err <= 1'b1;
    end else if (clr_err) begin
      r_overrun_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_push  (r_push),
    .i_wdata (r_shift),
    .i_pop   (ready_out),
    .o_rdata (data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign valid_out   = !w_empty;
  assign rx_busy     = (r_state != StIdle);
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an integrated receive FIFO. It is the next generation of the team's UART RX + RX buffer pair: configurable data width, bit timing and FIFO depth, plus error detection. It accepts the asynchronous serial line `rx` and presents received words on a valid/ready stream toward the APB register block. Frame and overrun errors are reported as sticky flags.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (e.g. 100 MHz / 115200); legal range >= 4
DATA_W, 8, data bits per frame; legal 5..9
STOP_BITS, 1, stop bits checked; legal 1 or 2
FIFO_DEPTH, 16, receive FIFO entries; power of 2, >= 2
CNT_W, $clog2(FIFO_DEPTH+1), width of the level output (derived; not overridden)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx  in  1  serial input; idle high; asynchronous to clk
en  in  1  receiver enable; 0 holds the FSM in IDLE
data_o  out  DATA_W  FIFO head word; meaningful only while valid_out=1
valid_out  out  1  FIFO not empty
ready_out  in  1  consumer accepts data_o when valid_out && ready_out
level  out  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH
rx_busy  out  1  FSM not in IDLE
frame_err  out  1  sticky: a stop bit was sampled low
overrun_err  out  1  sticky: a word arrived while the FIFO was full
clr_err  in  1  one-cycle pulse; clears both sticky flags

Behaviour:
- Reset (rstn=0, asynchronous): FSM in IDLE; FIFO empty; data_o=0, valid_out=0, level=0, rx_busy=0, frame_err=0, overrun_err=0; synchroniser flops set to 1. Reset mid-frame discards the partial word.
- `rx` passes through a 2-flop synchroniser. All sampling uses the synchronised value, rx_s.
- Bit counter counts 0..CLKS_PER_BIT-1. Data is sampled at the mid-bit point.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when en=1 and rx_s falls from 1 to 0.
  - START: at count CLKS_PER_BIT/2, if rx_s=1 the start was false -> IDLE with no error. Otherwise the counter restarts -> DATA.
  - DATA: DATA_W samples taken at full bit periods, LSB first, shifted into the shift register.
  - DATA -> PARITY when UART_RX_PARITY_EN is defined, otherwise -> STOP.
  - STOP: sample STOP_BITS times.
    - Every stop sample is 1: word is pushed.
    - Any stop sample is 0: word is dropped, frame_err=1, and the FSM waits for rx_s=1 before returning to IDLE.
- The push happens on the cycle after the final stop sample.
- FIFO full at push time: word dropped, overrun_err=1, FIFO contents unchanged.
- FIFO is first-word-fall-through. data_o is the head entry; a pop occurs when valid_out && ready_out.
- Push and pop in the same cycle: level unchanged, and this is legal even when full (pop frees the slot first, so no overrun).
- Latency: a pushed word appears on valid_out/data_o in the cycle after the push.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. level is tracked with a separate counter.
- en deassert mid-frame: the current frame completes. en is only sampled in IDLE.
- clr_err: clears both flags. If an error event occurs in the same cycle, the set wins.
- rx_busy=1 in every state except IDLE.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: adds parameter PARITY_ODD (default 0 = even parity) and output parity_err (sticky, cleared by clr_err).
  - The PARITY state samples one bit after the data bits.
  - On mismatch, parity_err=1 and the word is still pushed.
  - Frame length becomes 1 + DATA_W + 1 + STOP_BITS bits.
- Undefined: no PARITY state, no parity_err port, and the frame carries no parity bit.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - the 2-flop synchroniser depth constant
  - function clog2-based width helpers shared with the TX side
- Sub-module sync_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty/level. It is natural to split out and reusable by the TX path.
- The receive FSM stays in uart_rx_fifo.

Test Plan:
- Single frame: CLKS_PER_BIT=8, DATA_W=8, rx sends 0xA5 with a valid stop bit -> valid_out rises, data_o=0xA5, level=1; a ready_out pulse pops it -> level=0, valid_out=0.
- False start: rx low for 3 cycles then high (CLKS_PER_BIT=8) -> FSM back to IDLE, no push, no error flags.
- Framing error: frame 0x3C with the stop bit driven 0 -> frame_err=1, level unchanged; clr_err pulse -> frame_err=0.
- Overrun: FIFO_DEPTH=4, ready_out=0, send 5 frames 0x01..0x05 -> level=4, overrun_err=1; pop order 0x01,0x02,0x03,0x04.
- Full with simultaneous pop: FIFO full, ready_out=1 on the push cycle of a 6th frame -> no overrun, level stays 4, new word at tail.
- Reset mid-frame: assert rstn=0 during the DATA state -> all outputs 0 immediately; next full frame 0x5A is received correctly.
- With UART_RX_PARITY_EN (even): send 0x07 with the parity bit 0 -> parity_err=1 and 0x07 pushed.
